// File: rtl/io_irq_pkg.sv
// Shared definitions for io_irq_unit: register map, CTRL/STATUS bit positions,
// and the preemption timer state encoding.
package io_irq_pkg;

   localparam int ADDR_IN      = 'h10;
   localparam int ADDR_QUANTUM = 'h11;
   localparam int ADDR_CTRL    = 'h12;
   localparam int ADDR_EPC     = 'h13;
   localparam int ADDR_STATUS  = 'h14;

   localparam int CTRL_TIMER_EN = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_W        = 2;

   localparam int ST_PENDING = 0;
   localparam int ST_BTN_EVT = 1;
   localparam int ST_OVERRUN = 2;
   localparam int STATUS_W   = 3;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_PEND = 2'd2
   } timer_state_e;

endpackage

// File: rtl/io_irq_unit_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus an edge flop that
// yields a registered one-cycle pulse on each rising edge of the synced level.
module sync_edge (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_rise,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_pulse;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_meta  <= 1'b0;
         r_sync  <= 1'b0;
         r_prev  <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_meta  <= i_async;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_pulse <= r_sync & ~r_prev;
      end
   end

   // Combinational rise lets status logic latch the event on the same edge as the pulse.
   assign o_rise  = r_sync & ~r_prev;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/io_irq_unit.sv
// Memory-mapped IO block: N_OUT output registers, synchronised switch input,
// button edge detector and a preemption timer that raises irq and saves EPC on ack.
module io_irq_unit
   import io_irq_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_OUT  = 3,
   parameter int IN_W   = 18,
   parameter int ADDR_W = 5
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [ADDR_W-1:0]       i_addr,
   input  logic                    i_wr_en,
   input  logic [DATA_W-1:0]       i_wr_data,
   output logic [DATA_W-1:0]       o_rd_data,
   input  logic [IN_W-1:0]         i_in_raw,
   input  logic                    i_btn_n,
   output logic                    o_btn_pulse,
   input  logic [DATA_W-1:0]       i_pc_in,
   output logic                    o_irq,
   input  logic                    i_irq_ack,
   output logic [DATA_W-1:0]       o_epc,
   output logic [N_OUT*DATA_W-1:0] o_out_bus
);

   logic [N_OUT-1:0][DATA_W-1:0] r_out;
   logic [DATA_W-1:0]            r_quantum;
   logic [DATA_W-1:0]            r_cnt;
   logic [DATA_W-1:0]            r_epc;
   logic [CTRL_W-1:0]            r_ctrl;
   logic [STATUS_W-1:0]          r_status;
   logic [IN_W-1:0]              r_in_meta;
   logic [IN_W-1:0]              r_in_sync;
   logic                         r_irq;
   timer_state_e                 r_state;
   timer_state_e                 w_state_nxt;

   logic              w_wr_q;
   logic              w_wr_ctrl;
   logic              w_wr_stat;
   logic              w_run_ok;
   logic              w_active;
   logic              w_tc;
   logic              w_btn_rise;
   logic              w_btn_pulse;
   logic [DATA_W-1:0] w_rd_data;

   sync_edge u_btn (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (~i_btn_n),
      .o_rise  (w_btn_rise),
      .o_pulse (w_btn_pulse)
   );

   assign w_wr_q    = i_wr_en && (i_addr == ADDR_W'(ADDR_QUANTUM));
   assign w_wr_ctrl = i_wr_en && (i_addr == ADDR_W'(ADDR_CTRL));
   assign w_wr_stat = i_wr_en && (i_addr == ADDR_W'(ADDR_STATUS));

   // Counting only happens in a non-idle state while the timer is still enabled with a
   // non-zero quantum; the state register catches up one edge after those conditions drop.
   assign w_run_ok = r_ctrl[CTRL_TIMER_EN] && (r_quantum != '0);
   assign w_active = (r_state != T_IDLE) && w_run_ok;
   assign w_tc     = w_active && (r_cnt == DATA_W'(1));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= T_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!w_run_ok) begin
         w_state_nxt = T_IDLE;
      end else begin
         case (r_state)
            T_IDLE:  w_state_nxt = T_RUN;
            T_RUN:   if (w_tc) w_state_nxt = T_PEND;
            T_PEND:  if (i_irq_ack && !w_tc) w_state_nxt = T_RUN;
            default: w_state_nxt = T_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_out     <= '0;
         r_quantum <= '0;
         r_cnt     <= '0;
         r_ctrl    <= '0;
         r_status  <= '0;
         r_epc     <= '0;
         r_irq     <= 1'b0;
         r_in_meta <= '0;
         r_in_sync <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++)
            if (i_wr_en && (i_addr == ADDR_W'(k))) r_out[k] <= i_wr_data;

         if (w_wr_q)    r_quantum <= i_wr_data;
         if (w_wr_ctrl) r_ctrl    <= i_wr_data[CTRL_W-1:0];

         if (w_wr_q)
            r_cnt <= i_wr_data;
         else if (w_wr_ctrl || !w_active || w_tc)
            r_cnt <= r_quantum;
         else
            r_cnt <= r_cnt - DATA_W'(1);

         // Hardware sets take priority over ack / write-1-to-clear in the same cycle.
         r_status[ST_PENDING] <= w_tc | (r_status[ST_PENDING] & ~i_irq_ack);
         r_status[ST_OVERRUN] <= (w_tc & r_status[ST_PENDING]) |
                                 (r_status[ST_OVERRUN] & ~(w_wr_stat & i_wr_data[ST_OVERRUN]));
         r_status[ST_BTN_EVT] <= w_btn_rise |
                                 (r_status[ST_BTN_EVT] & ~(w_wr_stat & i_wr_data[ST_BTN_EVT]));

         r_irq <= r_status[ST_PENDING] & r_ctrl[CTRL_IRQ_EN];
         if (i_irq_ack) r_epc <= i_pc_in;

         r_in_meta <= i_in_raw;
         r_in_sync <= r_in_meta;
      end
   end

   always_comb begin
      w_rd_data = '0;
      for (int k = 0; k < N_OUT; k++)
         if (i_addr == ADDR_W'(k)) w_rd_data = r_out[k];
      if (i_addr == ADDR_W'(ADDR_IN))      w_rd_data = DATA_W'(r_in_sync);
      if (i_addr == ADDR_W'(ADDR_QUANTUM)) w_rd_data = r_quantum;
      if (i_addr == ADDR_W'(ADDR_CTRL))    w_rd_data = DATA_W'(r_ctrl);
      if (i_addr == ADDR_W'(ADDR_EPC))     w_rd_data = r_epc;
      if (i_addr == ADDR_W'(ADDR_STATUS))  w_rd_data = DATA_W'(r_status);
   end

   assign o_rd_data   = w_rd_data;
   assign o_btn_pulse = w_btn_pulse;
   assign o_irq       = r_irq;
   assign o_epc       = r_epc;
   assign o_out_bus   = r_out;

endmodule

// File: tb/tb_io_irq_unit.sv
// Bench for io_irq_unit: directed scenarios plus random traffic, all checked
// against a behavioural model (timer tracked as periodic events from an anchor cycle).
module tb_io_irq_unit;

   localparam int DW = 32;
   localparam int NO = 3;
   localparam int IW = 18;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addr;
   logic          wr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rd;
   logic [IW-1:0] in_raw;
   logic          btn_n;
   logic          pulse;
   logic [DW-1:0] pc;
   logic          irq;
   logic          ack;
   logic [DW-1:0] epc;
   logic [NO*DW-1:0] obus;

   always #5 clk = ~clk;

   io_irq_unit #(.DATA_W(DW), .N_OUT(NO), .IN_W(IW), .ADDR_W(AW)) dut (
      .i_clock(clk), .i_reset(rst), .i_addr(addr), .i_wr_en(wr), .i_wr_data(wdata),
      .o_rd_data(rd), .i_in_raw(in_raw), .i_btn_n(btn_n), .o_btn_pulse(pulse),
      .i_pc_in(pc), .o_irq(irq), .i_irq_ack(ack), .o_epc(epc), .o_out_bus(obus)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] m_out [NO];
   logic [DW-1:0] m_q, m_epc;
   logic [IW-1:0] m_in_m, m_in_s;
   bit            m_en, m_ien, m_pend, m_bevt, m_ovr, m_irq, m_pulse, m_counting;
   bit   [2:0]    m_bh;   // pressed level sampled 1, 2, 3 edges ago (bit0 newest)
   longint        m_n, m_anchor;

   task automatic m_reset();
      for (int k = 0; k < NO; k++) m_out[k] = '0;
      m_q = '0; m_epc = '0; m_in_m = '0; m_in_s = '0;
      m_en = 0; m_ien = 0; m_pend = 0; m_bevt = 0; m_ovr = 0; m_irq = 0; m_pulse = 0;
      m_counting = 0; m_bh = '0; m_n = 0; m_anchor = 0;
   endtask

   function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
      if (a < NO) return m_out[a];
      case (a)
         5'h10:   return DW'(m_in_s);
         5'h11:   return m_q;
         5'h12:   return DW'({m_ien, m_en});
         5'h13:   return m_epc;
         5'h14:   return DW'({m_ovr, m_bevt, m_pend});
         default: return '0;
      endcase
   endfunction

   // Interrupt events fall every QUANTUM edges after the last (re)load point.
   task automatic m_edge();
      bit ok, tc, rise, wst;
      m_n++;
      ok = m_en && (m_q != 0);
      tc = 0;
      if (m_counting && ok) tc = ((m_n - m_anchor) % longint'(m_q)) == 0;
      else                  m_anchor = m_n;
      rise = m_bh[1] & ~m_bh[2];
      wst  = wr && (addr == 5'h14);
      m_irq   = m_pend & m_ien;
      m_ovr   = (tc & m_pend) | (m_ovr & ~(wst & wdata[2]));
      m_bevt  = rise | (m_bevt & ~(wst & wdata[1]));
      m_pend  = tc | (m_pend & ~ack);
      m_pulse = rise;
      if (ack) m_epc = pc;
      m_bh   = {m_bh[1], m_bh[0], ~btn_n};
      m_in_s = m_in_m;
      m_in_m = in_raw;
      m_counting = ok;
      if (wr) begin
         if (addr < NO) m_out[addr] = wdata;
         if (addr == 5'h11) begin m_q = wdata; m_anchor = m_n; end
         if (addr == 5'h12) begin m_en = wdata[0]; m_ien = wdata[1]; m_anchor = m_n; end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic chk_outs();
      chk("irq", irq, m_irq);
      chk("btn_pulse", pulse, m_pulse);
      chk("epc", epc, m_epc);
      for (int k = 0; k < NO; k++) chk($sformatf("out%0d", k), obus[k*DW +: DW], m_out[k]);
   endtask

   task automatic step();
      #1;
      chk($sformatf("rd@%0h", addr), rd, m_rd(addr));
      @(posedge clk);
      m_edge();
      #1;
      chk_outs();
   endtask

   task automatic drive(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
      addr = a; wr = w; wdata = d; ack = 1'b0;
   endtask

   int alist [13] = '{0, 1, 2, 3, 7, 15, 'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h1f};

   initial begin
      int a, npulse, pidx, nirq;
      rst = 1'b1; addr = '0; wr = 0; wdata = '0; in_raw = '0; btn_n = 1'b1; pc = '0; ack = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_outs();
      for (int i = 0; i < 13; i++) begin
         addr = AW'(alist[i]);
         #0.1;
         chk("rd_reset", rd, m_rd(addr));
      end
      rst = 1'b0;

      // output registers and unmapped write
      drive(0, 1, 32'hA5A5A5A5); step();
      drive(1, 1, 32'h5A5A5A5A); step();
      drive(2, 1, 32'hDEADBEEF); step();
      chk("out2_dead", obus[95:64], 32'hDEADBEEF);
      chk("out0_keep", obus[31:0], 32'hA5A5A5A5);
      drive(7, 1, 32'h12345678); step();
      chk("out1_keep", obus[63:32], 32'h5A5A5A5A);
      drive(5'h13, 1, 32'h77); step();   // ro register

      // timer period 5, overrun, ack
      drive(5'h11, 1, 5); step();
      drive(5'h12, 1, 3); step();
      drive(5'h14, 0, 0);
      repeat (11) step();
      #1 chk("status101", rd, 5);
      drive(5'h14, 0, 0); ack = 1; pc = 32'h40; step();
      ack = 0;
      chk("epc40", epc, 32'h40);
      step();
      chk("irq_fall", irq, 0);
      repeat (7) step();
      // ack lands on a terminal count
      ack = 1; pc = 32'h80; step();
      ack = 0;
      chk("epc80", epc, 32'h80);
      chk("irq_hold", irq, 1);
      step();
      chk("irq_hold2", irq, 1);
      #1 chk("pend_kept", rd[0], 1);

      // asynchronous reset mid-run
      drive(5'h12, 0, 0);
      rst = 1'b1;
      #1;
      chk("rst_irq", irq, 0);
      chk("rst_pulse", pulse, 0);
      chk("rst_bus", obus, '0);
      chk("rst_ctrl", rd, 0);
      m_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      step();
      chk("rel_ctrl", rd, 0);

      // button: one pulse per press
      drive(5'h14, 0, 0);
      btn_n = 1'b0;
      npulse = 0; pidx = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (pulse) begin npulse++; if (pidx < 0) pidx = i; end
      end
      chk("btn_count", npulse, 1);
      chk("btn_lat", pidx, 2);
      #1 chk("btn_evt", rd[1], 1);
      btn_n = 1'b1;
      drive(5'h14, 1, 2); step();
      drive(5'h14, 0, 0);
      #1 chk("btn_evt_clr", rd[1], 0);

      // input sync and zero quantum
      in_raw = 18'h2ABCD;
      drive(5'h10, 0, 0); step(); step();
      #1 chk("in_sync", rd, 32'h0002ABCD);
      drive(5'h11, 1, 0); step();
      drive(5'h12, 1, 3); step();
      drive(5'h14, 0, 0);
      nirq = 0;
      for (int i = 0; i < 20; i++) begin step(); if (irq) nirq++; end
      chk("q0_noirq", nirq, 0);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         a = alist[$urandom_range(0, 12)];
         addr = AW'(a);
         wr = ($urandom_range(0, 9) < 2);
         wdata = (a == 'h11) ? DW'($urandom_range(0, 7)) : DW'($urandom);
         ack = ($urandom_range(0, 7) == 0);
         pc = $urandom;
         if ($urandom_range(0, 15) == 0) in_raw = IW'($urandom);
         if ($urandom_range(0, 11) == 0) btn_n = ~btn_n;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
